// File: rtl/exec_pkg.sv
// Shared definitions for the accumulator executor: opcode encodings and FSM states.
package exec_pkg;

    localparam int OPCODE_W = 5;

    localparam logic [4:0] OP_LI   = 5'h00;
    localparam logic [4:0] OP_MOVT = 5'h01;
    localparam logic [4:0] OP_MOVF = 5'h02;
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h05;
    localparam logic [4:0] OP_OR   = 5'h06;
    localparam logic [4:0] OP_XOR  = 5'h07;
    localparam logic [4:0] OP_LD   = 5'h08;
    localparam logic [4:0] OP_ST   = 5'h09;
    localparam logic [4:0] OP_MUL  = 5'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MEM  = 2'b01,
        ST_MUL  = 2'b10
    } state_e;

endpackage

// File: rtl/exec_unit_if.sv
// Decoder-side instruction handshake plus data-memory port of the executor.
// master = environment (decoder + memory), slave = exec_unit.
interface exec_unit_if #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int IMM_W  = 3
) ();
    import exec_pkg::*;

    localparam int REG_W = $clog2(NREGS);

    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    register;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   acc;
    logic                flag_z;
    logic                flag_c;
    logic                retire;
    logic                illegal;
    logic                mem_req;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    modport master (
        output in_valid, opcode, register, imm, mem_rdata, mem_ack,
        input  in_ready, acc, flag_z, flag_c, retire, illegal,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, opcode, register, imm, mem_rdata, mem_ack,
        output in_ready, acc, flag_z, flag_c, retire, illegal,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/exec_mul.sv
// Sequential shift-add multiplier. Bit 0 of the multiplier is consumed in
// the start cycle, the remaining DATA_W-1 bits one per cycle; done_o pulses
// for one cycle once product_o holds the full 2*DATA_W result.
module exec_mul #(
    parameter int DATA_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mult_q,  mult_d;
    logic [2*DATA_W-1:0] prod_q,  prod_d;

    // Next-state: load operands on start, then one partial product per cycle.
    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        prod_d  = prod_q;
        if (start_i) begin
            if (b_i[0]) begin
                prod_d = {{DATA_W{1'b0}}, a_i};
            end else begin
                prod_d = {(2*DATA_W){1'b0}};
            end
            mcand_d = {{(DATA_W-1){1'b0}}, a_i, 1'b0};
            mult_d  = {1'b0, b_i[DATA_W-1:1]};
            cnt_d   = CNT_W'(DATA_W - 1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (mult_q[0]) begin
                prod_d = prod_q + mcand_q;
            end else begin
                prod_d = prod_q;
            end
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state registers; reset discards any partial product.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            mcand_q <= {(2*DATA_W){1'b0}};
            mult_q  <= {DATA_W{1'b0}};
            prod_q  <= {(2*DATA_W){1'b0}};
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            prod_q  <= prod_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = prod_q;

endmodule

// File: rtl/exec_unit.sv
// Accumulator-ISA executor: accumulator, Z/C flags and NREGS register file,
// single-cycle ALU ops, req/ack loads/stores.
// Optional multi-cycle MUL enabled by defining EXEC_UNIT_MUL_EN; without it
// opcode MUL is treated as illegal and the multiplier is not built.
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int IMM_W  = 3
) (
    input  logic       clk,
    input  logic       reset,
    exec_unit_if.slave bus
);

    localparam int REG_W = $clog2(NREGS);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;
    logic              in_ready_q, in_ready_d;
    logic              retire_q, retire_d;
    logic              illegal_q, illegal_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic              accept_s;
    logic              acc_wr_s;
    logic              wr_en_s;
    logic [REG_W-1:0]  wr_idx_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] operand_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W:0]   diff_s;

`ifdef EXEC_UNIT_MUL_EN
    logic                mul_start_s;
    logic                mul_busy_s;
    logic                mul_done_s;
    logic [2*DATA_W-1:0] mul_prod_s;

    exec_mul #(.DATA_W(DATA_W)) u_mul (
        .clk_i     (clk),
        .rst_ni    (reset),
        .start_i   (mul_start_s),
        .a_i       (acc_q),
        .b_i       (operand_s),
        .busy_o    (mul_busy_s),
        .done_o    (mul_done_s),
        .product_o (mul_prod_s)
    );
`endif

    // in_ready is only ever high in IDLE, so it alone qualifies acceptance.
    assign accept_s  = bus.in_valid & in_ready_q;
    assign operand_s = regs_q[bus.register];
    assign sum_s     = {1'b0, acc_q} + {1'b0, operand_s};
    assign diff_s    = {1'b0, acc_q} - {1'b0, operand_s};

    // Instruction decode, FSM transitions and next architectural state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        in_ready_d  = in_ready_q;
        retire_d    = 1'b0;
        illegal_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_en_s     = 1'b0;
        wr_idx_s    = bus.register;
        wr_data_s   = acc_q;
        acc_wr_s    = 1'b0;
`ifdef EXEC_UNIT_MUL_EN
        mul_start_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (bus.opcode)
                        OP_LI: begin
                            acc_d    = DATA_W'(bus.imm);
                            acc_wr_s = 1'b1;
                            retire_d = 1'b1;
                        end
                        OP_MOVT: begin
                            wr_en_s  = 1'b1;
                            retire_d = 1'b1;
                        end
                        OP_MOVF: begin
                            acc_d    = operand_s;
                            acc_wr_s = 1'b1;
                            retire_d = 1'b1;
                        end
                        OP_ADD: begin
                            {flag_c_d, acc_d} = sum_s;
                            acc_wr_s = 1'b1;
                            retire_d = 1'b1;
                        end
                        OP_SUB: begin
                            // MSB of the widened difference is the borrow.
                            {flag_c_d, acc_d} = diff_s;
                            acc_wr_s = 1'b1;
                            retire_d = 1'b1;
                        end
                        OP_AND: begin
                            acc_d    = acc_q & operand_s;
                            acc_wr_s = 1'b1;
                            retire_d = 1'b1;
                        end
                        OP_OR: begin
                            acc_d    = acc_q | operand_s;
                            acc_wr_s = 1'b1;
                            retire_d = 1'b1;
                        end
                        OP_XOR: begin
                            acc_d    = acc_q ^ operand_s;
                            acc_wr_s = 1'b1;
                            retire_d = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            state_d    = ST_MEM;
                            in_ready_d = 1'b0;
                            mem_req_d  = 1'b1;
                            mem_we_d   = (bus.opcode == OP_ST);
                            mem_addr_d = operand_s;
                            if (bus.opcode == OP_ST) begin
                                mem_wdata_d = acc_q;
                            end else begin
                                mem_wdata_d = mem_wdata_q;
                            end
                        end
`ifdef EXEC_UNIT_MUL_EN
                        OP_MUL: begin
                            state_d     = ST_MUL;
                            in_ready_d  = 1'b0;
                            mul_start_s = 1'b1;
                        end
`endif
                        default: begin
                            illegal_d = 1'b1;
                            retire_d  = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    retire_d   = 1'b1;
                    if (!mem_we_q) begin
                        acc_d    = bus.mem_rdata;
                        acc_wr_s = 1'b1;
                    end else begin
                        acc_d = acc_q;
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_MUL: begin
`ifdef EXEC_UNIT_MUL_EN
                if (mul_done_s) begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                    retire_d   = 1'b1;
                    acc_d      = mul_prod_s[DATA_W-1:0];
                    flag_c_d   = |mul_prod_s[2*DATA_W-1:DATA_W];
                    acc_wr_s   = 1'b1;
                end else if (!mul_busy_s) begin
                    // Multiplier idle without a result: recover to IDLE.
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    state_d = ST_MUL;
                end
`else
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
`endif
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
            end
        endcase
        if (acc_wr_s) begin
            flag_z_d = (acc_d == {DATA_W{1'b0}});
        end else begin
            flag_z_d = flag_z_q;
        end
    end

    // Architectural and output registers; reset also drops mem_req at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= {DATA_W{1'b0}};
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            retire_q    <= 1'b0;
            illegal_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {DATA_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
            in_ready_q  <= in_ready_d;
            retire_q    <= retire_d;
            illegal_q   <= illegal_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Register file: cleared on reset, written only by MOVT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_q[wr_idx_s] <= wr_data_s;
        end else begin
            regs_q[wr_idx_s] <= regs_q[wr_idx_s];
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.acc       = acc_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.retire    = retire_q;
    assign bus.illegal   = illegal_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit (DATA_W=8, NREGS=8, IMM_W=3). MUL expectations
// follow EXEC_UNIT_MUL_EN.
module tb_exec_unit;
    import exec_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    exec_unit_if #(.DATA_W(8), .NREGS(8), .IMM_W(3)) bus ();

    exec_unit #(.DATA_W(8), .NREGS(8), .IMM_W(3)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one instruction for a single accept edge, return at the next negedge.
    task automatic issue(input logic [4:0] op, input logic [2:0] r, input logic [2:0] im);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.register = r;
        bus.imm      = im;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Zero-wait load from R1 returning data.
    task automatic load_val(input logic [7:0] data);
        issue(OP_LD, 3'd1, 3'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = 5'h00;
        bus.register  = 3'd0;
        bus.imm       = 3'd0;
        bus.mem_rdata = 8'h00;
        bus.mem_ack   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_acc",      32'(bus.acc),       32'h0);
        check("rst_flags",    32'({bus.flag_z, bus.flag_c}), 32'h0);
        check("rst_retire",   32'(bus.retire),    32'h0);
        check("rst_illegal",  32'(bus.illegal),   32'h0);
        check("rst_mem_req",  32'({bus.mem_req, bus.mem_we}), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr),  32'h0);
        check("rst_wdata",    32'(bus.mem_wdata), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready),  32'h1);
        reset = 1'b1;

        // LI
        issue(OP_LI, 3'd0, 3'd5);
        check("li5_acc",    32'(bus.acc),    32'h05);
        check("li5_z",      32'(bus.flag_z), 32'h0);
        check("li5_retire", 32'(bus.retire), 32'h1);
        @(negedge clk);
        check("li5_retire_fall", 32'(bus.retire), 32'h0);
        issue(OP_LI, 3'd0, 3'd0);
        check("li0_acc", 32'(bus.acc),    32'h00);
        check("li0_z",   32'(bus.flag_z), 32'h1);

        // ADD
        issue(OP_LI,   3'd0, 3'd7);
        issue(OP_MOVT, 3'd2, 3'd0);
        issue(OP_LI,   3'd0, 3'd1);
        issue(OP_ADD,  3'd2, 3'd0);
        check("add_acc", 32'(bus.acc),    32'h08);
        check("add_c",   32'(bus.flag_c), 32'h0);

        // ADD overflow: R3=7, build acc=0xFF by acc = 2*acc + 1
        issue(OP_LI,   3'd0, 3'd7);
        issue(OP_MOVT, 3'd3, 3'd0);
        issue(OP_LI,   3'd0, 3'd1);
        issue(OP_MOVT, 3'd6, 3'd0);
        for (int i = 0; i < 7; i++) begin
            issue(OP_MOVT, 3'd5, 3'd0);
            issue(OP_ADD,  3'd5, 3'd0);
            issue(OP_ADD,  3'd6, 3'd0);
        end
        check("build_ff_acc", 32'(bus.acc),    32'hFF);
        check("build_ff_c",   32'(bus.flag_c), 32'h0);
        issue(OP_ADD, 3'd3, 3'd0);
        check("ovf_acc", 32'(bus.acc),    32'h06);
        check("ovf_c",   32'(bus.flag_c), 32'h1);
        check("ovf_z",   32'(bus.flag_z), 32'h0);

        // SUB
        issue(OP_LI,  3'd0, 3'd7);
        issue(OP_SUB, 3'd3, 3'd0);
        check("sub_eq_acc", 32'(bus.acc),    32'h00);
        check("sub_eq_c",   32'(bus.flag_c), 32'h0);
        check("sub_eq_z",   32'(bus.flag_z), 32'h1);
        issue(OP_LI,  3'd0, 3'd2);
        issue(OP_SUB, 3'd3, 3'd0);
        check("sub_brw_acc", 32'(bus.acc),    32'hFB);
        check("sub_brw_c",   32'(bus.flag_c), 32'h1);

        // Logic ops keep flag_c
        issue(OP_LI,  3'd0, 3'd5);
        issue(OP_XOR, 3'd3, 3'd0);
        check("xor_acc", 32'(bus.acc),    32'h02);
        check("xor_c",   32'(bus.flag_c), 32'h1);
        issue(OP_LI,  3'd0, 3'd0);
        issue(OP_AND, 3'd3, 3'd0);
        check("and_z", 32'({bus.flag_z, bus.acc}), 32'h100);
        issue(OP_OR, 3'd3, 3'd0);
        check("or_acc", 32'(bus.acc), 32'h07);
        issue(OP_LI,   3'd0, 3'd0);
        issue(OP_MOVF, 3'd2, 3'd0);
        check("movf_acc", 32'(bus.acc), 32'h07);

        // R1 = 0x10
        issue(OP_LI,   3'd0, 3'd4);
        issue(OP_MOVT, 3'd1, 3'd0);
        issue(OP_ADD,  3'd1, 3'd0);
        issue(OP_MOVT, 3'd1, 3'd0);
        issue(OP_ADD,  3'd1, 3'd0);
        issue(OP_MOVT, 3'd1, 3'd0);
        check("r1_acc", 32'(bus.acc), 32'h10);

        // LD with wait states
        issue(OP_LD, 3'd1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ld_wait_req%0d", i),   32'({bus.mem_req, bus.mem_we}), 32'h2);
            check($sformatf("ld_wait_addr%0d", i),  32'(bus.mem_addr), 32'h10);
            check($sformatf("ld_wait_rdy%0d", i),   32'(bus.in_ready), 32'h0);
            check($sformatf("ld_wait_ret%0d", i),   32'(bus.retire),   32'h0);
            @(negedge clk);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hA5;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("ld_acc",    32'(bus.acc),      32'hA5);
        check("ld_retire", 32'(bus.retire),   32'h1);
        check("ld_req",    32'(bus.mem_req),  32'h0);
        check("ld_ready",  32'(bus.in_ready), 32'h1);

        // ST zero-wait, ack held from the accept cycle, then back-to-back LI
        issue(OP_LI, 3'd0, 3'd6);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_ST;
        bus.register = 3'd1;
        bus.mem_ack  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("st_req",    32'({bus.mem_req, bus.mem_we}), 32'h3);
        check("st_wdata",  32'(bus.mem_wdata), 32'h06);
        check("st_addr",   32'(bus.mem_addr),  32'h10);
        check("st_ret0",   32'(bus.retire),    32'h0);
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("st_retire", 32'(bus.retire),    32'h1);
        check("st_req_off",32'(bus.mem_req),   32'h0);
        check("st_ready",  32'(bus.in_ready),  32'h1);
        check("st_acc",    32'(bus.acc),       32'h06);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_LI;
        bus.imm      = 3'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_acc",    32'(bus.acc),    32'h03);
        check("b2b_retire", 32'(bus.retire), 32'h1);

        // Unknown opcode
        issue(5'h1F, 3'd3, 3'd0);
        check("ill_pulse",  32'({bus.illegal, bus.retire}), 32'h3);
        check("ill_acc",    32'(bus.acc),    32'h03);
        check("ill_z",      32'(bus.flag_z), 32'h0);
        @(negedge clk);
        check("ill_fall",   32'(bus.illegal), 32'h0);

        // MUL 0x12 * 0x10
        load_val(8'h12);
        check("mul_pre_acc", 32'(bus.acc), 32'h12);
        issue(OP_MUL, 3'd1, 3'd0);
`ifdef EXEC_UNIT_MUL_EN
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("mul_busy%0d", i), 32'({bus.in_ready, bus.retire}), 32'h0);
        end
        @(negedge clk);
        check("mul_acc",    32'(bus.acc),      32'h20);
        check("mul_c",      32'(bus.flag_c),   32'h1);
        check("mul_retire", 32'(bus.retire),   32'h1);
        check("mul_ready",  32'(bus.in_ready), 32'h1);
`else
        check("mul_ill",   32'({bus.illegal, bus.retire}), 32'h3);
        check("mul_acc",   32'(bus.acc),      32'h12);
        check("mul_ready", 32'(bus.in_ready), 32'h1);
`endif

        // Reset mid-MEM
        issue(OP_LD, 3'd1, 3'd0);
        check("mid_req_on", 32'(bus.mem_req), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_req_async", 32'(bus.mem_req),  32'h0);
        check("mid_acc",       32'(bus.acc),      32'h0);
        check("mid_addr",      32'(bus.mem_addr), 32'h0);
        check("mid_ready",     32'(bus.in_ready), 32'h1);
        check("mid_misc",      32'({bus.flag_z, bus.flag_c, bus.retire, bus.illegal, bus.mem_we}), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        issue(OP_LI, 3'd0, 3'd4);
        check("post_rst_acc", 32'(bus.acc), 32'h04);
        issue(OP_MOVF, 3'd1, 3'd0);
        check("post_rst_r1", 32'({bus.flag_z, bus.acc}), 32'h100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised successor to the single-opcode executor for the accumulator ISA. The accumulator, zero/carry flags and an NREGS-entry register file are held internally. Decoded instructions arrive on a valid/ready handshake; ALU ops retire in one cycle, loads and stores use a req/ack memory port, and an optional multi-cycle multiply is supported. The block sits between the decoder and the data-memory interface.

## Interface
- DATA_W, 8: accumulator, register and memory data width (≥4)
- NREGS, 8: register-file entries (power of two); REG_W = $clog2(NREGS)
- IMM_W, 3: immediate width (< DATA_W)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  executor can accept this cycle
- opcode  in  5  operation; encodings from the package
- register  in  REG_W  register-file index
- imm  in  IMM_W  immediate
- acc  out  DATA_W  accumulator
- flag_z, flag_c  out  1  zero flag, carry/borrow flag
- retire  out  1  one-cycle pulse per completed instruction
- illegal  out  1  one-cycle pulse on an unknown opcode
- mem_req, mem_we  out  1  memory request; 1 = store
- mem_addr, mem_wdata  out  DATA_W  address and store data
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  memory completion

## Operation
- Opcodes: LI=0x00, MOVT=0x01, MOVF=0x02, ADD=0x03, SUB=0x04, AND=0x05, OR=0x06, XOR=0x07, LD=0x08, ST=0x09, MUL=0x0A.
- LI: acc <= imm zero-extended to DATA_W.
- MOVT: R[register] <= acc. MOVF: acc <= R[register].
- ADD/SUB: acc <= acc ± R[register], modulo 2^DATA_W.
  - flag_c = carry-out for ADD; flag_c = borrow (acc < R) for SUB.
- AND/OR/XOR: bitwise on acc and R[register]; flag_c unchanged.
- flag_z <= (new acc == 0) on every acc-writing op. Stores, MOVT and illegal ops leave both flags unchanged.
- LD: mem_addr = R[register]; on ack, acc <= mem_rdata.
- ST: mem_addr = R[register], mem_wdata = acc.
- MUL: acc <= low DATA_W bits of acc*R[register]; flag_c = 1 if the high half ≠ 0.
- Unknown opcode: illegal pulse, retire pulse, no state change.
- FSM states:
  - IDLE: in_ready=1. Single-cycle ops complete at the accept edge. LD/ST -> MEM. MUL -> MUL.
  - MEM: in_ready=0, mem_req=1; address/data/we held stable. mem_ack -> IDLE.
  - MUL: in_ready=0, shift-add, one bit per cycle; after DATA_W cycles -> IDLE.
- mem_ack in IDLE/MUL is ignored.
- Reset values: acc=0, all R=0, flags=0, state=IDLE, retire=illegal=mem_req=mem_we=0, mem_addr=mem_wdata=0.
- Reset mid-MEM or mid-MUL aborts immediately; mem_req deasserts asynchronously and the partial result is discarded.

## Timing
- Single-cycle ops: accept at edge T; acc/flags/R valid after T; retire high T..T+1. Throughput 1 per cycle.
- LD/ST: mem_req high from T+1. With ack at edge A: acc update (LD) and retire in the cycle after A; in_ready high after A.
- Zero-wait memory (ack in the first req cycle) gives 2-cycle LD/ST.
- MUL: in_ready low for DATA_W cycles; result and retire after edge T+DATA_W.
- in_ready is registered, not combinational from in_valid.

## Configuration
- EXEC_UNIT_MUL_EN defined: MUL implemented as above.
- Undefined: opcode 0x0A is illegal (pulses illegal, no state change), the MUL state and multiplier are removed, and LUT/flop count drops.

## Structure
- Package exec_pkg: opcode localparams (OP_LI … OP_MUL), state enum typedef (ST_IDLE, ST_MEM, ST_MUL).
- Sub-module exec_mul: sequential shift-add multiplier with start/busy/done and a 2*DATA_W product. Instantiated only under EXEC_UNIT_MUL_EN.
- Register file as an internal flop array; no sub-module.

## Test plan
- Reset, then LI imm=5 -> acc=0x05, flag_z=0, retire one cycle; LI imm=0 -> flag_z=1.
- LI 7, MOVT R2, LI 1, ADD R2 -> acc=0x08. LI 7, MOVT R3, LI 0xFF-style overflow (acc=0xFF via repeated ADD) + R3 -> wraps, flag_c=1. SUB where acc<R -> borrow flag_c=1.
- LD R1 (R1=0x10), ack after 3 wait cycles, rdata=0xA5 -> mem_addr=0x10 stable, in_ready=0 throughout, acc=0xA5 after ack.
- ST with zero-wait ack -> mem_we=1, mem_wdata=acc; 2-cycle retire; back-to-back ALU op accepted next cycle.
- MUL acc=0x12, R=0x10 (DATA_W=8) with macro -> acc=0x20, flag_c=1, busy 8 cycles. Without macro -> illegal pulse, acc unchanged.
- Reset asserted mid-MEM -> mem_req falls without waiting for a clock edge, all outputs return to reset values, next instruction accepted normally after release.
